// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the CPU port, debug port and memory-side signals
// of the VeriRISC memory arbiter.
// slave  : the arbiter's view (takes requests, drives grants and memory strobes)
// master : the environment's view (requesters plus the memory model)
// Handshake: a requester raises req with we/addr/wdata stable, the arbiter
// answers with gnt for the whole access and a one-cycle done pulse after it;
// the requester drops req at the edge that ends its done cycle, and a req
// still high in the following IDLE cycle is a new request.
interface mem_arbiter_if #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8
);
    logic              cpu_req;
    logic              cpu_we;
    logic [AWIDTH-1:0] cpu_addr;
    logic [DWIDTH-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_done;

    logic              dbg_req;
    logic              dbg_we;
    logic [AWIDTH-1:0] dbg_addr;
    logic [DWIDTH-1:0] dbg_wdata;
    logic              dbg_gnt;
    logic              dbg_done;

    logic              mem_rd;
    logic              mem_wr;
    logic [AWIDTH-1:0] mem_addr;
    logic [DWIDTH-1:0] mem_wdata;
    logic [DWIDTH-1:0] mem_rdata;
    logic [DWIDTH-1:0] rdata_q;
    logic              busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  mem_rdata,
        output cpu_gnt, cpu_done, dbg_gnt, dbg_done,
        output mem_rd, mem_wr, mem_addr, mem_wdata, rdata_q, busy
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output mem_rdata,
        input  cpu_gnt, cpu_done, dbg_gnt, dbg_done,
        input  mem_rd, mem_wr, mem_addr, mem_wdata, rdata_q, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port VeriRISC memory between the CPU and a
// debug/loader port. One access at a time, IDLE -> ACCESS (ACCESS_CYCLES
// cycles) -> DONE -> IDLE. Read strobe is held for the whole access, the
// write strobe only in its final cycle. Read data is captured at the end of
// a read and held until the next read or reset.
// Optional feature: define MEM_ARB_RR_EN for round-robin on a tie (the port
// that did not win last time wins, first tie after reset goes to the CPU);
// without it the CPU always wins a tie.
// state_dbg exposes the FSM state (IDLE=0, ACCESS=1, DONE=2).
module mem_arbiter #(
    parameter int AWIDTH        = 5,
    parameter int DWIDTH        = 8,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst_,
    mem_arbiter_if.slave bus,
    output logic [1:0]   state_dbg
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(ACCESS_CYCLES - 1);
    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DBG = 1'b1;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q;
    // Owner of the current/last access; with round-robin enabled this is
    // also the last_gnt history, hence the DBG reset value.
    logic              owner_q;
    logic              we_q;
    logic [AWIDTH-1:0] addr_q;
    logic [DWIDTH-1:0] wdata_q;
    logic [DWIDTH-1:0] rdata_r;
    logic              any_req;
    logic              win;

    assign any_req = bus.cpu_req | bus.dbg_req;

    // Pick the winner among the requests currently seen in IDLE.
    always_comb begin
        win = OWN_CPU;
        if (bus.cpu_req && bus.dbg_req) begin
`ifdef MEM_ARB_RR_EN
            win = (owner_q == OWN_CPU) ? OWN_DBG : OWN_CPU;
`else
            win = OWN_CPU;
`endif
        end else if (bus.dbg_req) begin
            win = OWN_DBG;
        end
    end

    // FSM state register; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (any_req) state_d = S_ACCESS;
            S_ACCESS: if (cnt_q == '0) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Latch the winner's request on grant, count the access, capture read data.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            cnt_q   <= '0;
            owner_q <= OWN_DBG;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_r <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (any_req) begin
                        owner_q <= win;
                        we_q    <= (win == OWN_DBG) ? bus.dbg_we    : bus.cpu_we;
                        addr_q  <= (win == OWN_DBG) ? bus.dbg_addr  : bus.cpu_addr;
                        wdata_q <= (win == OWN_DBG) ? bus.dbg_wdata : bus.cpu_wdata;
                        cnt_q   <= CNT_LOAD;
                    end
                end
                S_ACCESS: begin
                    if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
                    else if (!we_q)  rdata_r <= bus.mem_rdata;
                end
                default: ;
            endcase
        end
    end

    // All outputs decode registered state only; no req-to-gnt path.
    assign bus.cpu_gnt   = (state_q == S_ACCESS) && (owner_q == OWN_CPU);
    assign bus.dbg_gnt   = (state_q == S_ACCESS) && (owner_q == OWN_DBG);
    assign bus.cpu_done  = (state_q == S_DONE)   && (owner_q == OWN_CPU);
    assign bus.dbg_done  = (state_q == S_DONE)   && (owner_q == OWN_DBG);
    assign bus.mem_rd    = (state_q == S_ACCESS) && !we_q;
    assign bus.mem_wr    = (state_q == S_ACCESS) && we_q && (cnt_q == '0);
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.rdata_q   = rdata_r;
    assign bus.busy      = (state_q != S_IDLE);
    assign state_dbg     = state_q;
endmodule
